// File: rtl/cpri_rxdata_unpack_pkg.sv
// Shared constants and the word-class type for the CPRI receive unpacker.
package cpri_rxdata_unpack_pkg;

  localparam int CPRI_WORD_W   = 64;
  localparam int SEQ_CTRL_LAST = 1;
  localparam int SEQ_LAST      = 95;

  // Class of one received word within the 96-word basic-frame group.
  typedef enum logic [1:0] {
    CTRL    = 2'd0,
    IQ      = 2'd1,
    INVALID = 2'd2
  } word_class_t;

endpackage

// File: rtl/cpri_seq_decode.sv
// Combinational classifier: word index within the basic-frame group -> word class.
module cpri_seq_decode
  import cpri_rxdata_unpack_pkg::*;
(
  input  logic [6:0]  seq,
  output word_class_t word_class
);

  // Seq 0..1 carry control words, 2..95 carry IQ, anything above is out of range.
  // NOTE: always_comb assigns a default first so every path drives the output and no latch is inferred.
  always_comb begin
    word_class = INVALID;
    if (seq <= 7'(SEQ_CTRL_LAST)) begin
      word_class = CTRL;
    end else if (seq <= 7'(SEQ_LAST)) begin
      word_class = IQ;
    end
  end

endmodule

// File: rtl/cpri_rxdata_unpack.sv
// Splits each 64-bit CPRI receive word into ANT lanes of DW bits and steers it
// to the IQ output or the control/management output according to its seq index.
module cpri_rxdata_unpack
  import cpri_rxdata_unpack_pkg::*;
#(
  parameter int DW    = 8,
  parameter int ANT   = 8,
  parameter int numRE = 12
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [CPRI_WORD_W-1:0]  i_cpri_rx_data,
  input  logic [6:0]              i_cpri_rx_seq,
  output logic [ANT-1:0][DW-1:0]  o_iq_data,
  output logic [ANT-1:0][DW-1:0]  o_cm_data
);

  // The lanes must tile the receive word exactly; numRE only describes the
  // resource grid and must merely be sensible.
  if (ANT * DW != CPRI_WORD_W) begin : g_bad_lane_cfg
    $fatal(1, "cpri_rxdata_unpack: ANT*DW must equal the 64-bit CPRI word");
  end
  if (numRE < 1) begin : g_bad_numre
    $fatal(1, "cpri_rxdata_unpack: numRE must be positive");
  end

  word_class_t            word_class;
  logic [ANT-1:0][DW-1:0] lanes;

  cpri_seq_decode u_seq_decode (
    .seq        (i_cpri_rx_seq),
    .word_class (word_class)
  );

  // Lane a takes bits [a*DW +: DW]; lane 0 is the least significant slice.
  always_comb begin
    lanes = '0;
    for (int a = 0; a < ANT; a++) begin
      lanes[a] = i_cpri_rx_data[a*DW +: DW];
    end
  end

  // Output registers: IQ is loaded or zeroed every cycle, control data is
  // loaded on control words and otherwise held until the next one.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_iq_data <= '0;
      o_cm_data <= '0;
    end else begin
      o_iq_data <= (word_class == IQ) ? lanes : '0;
      if (word_class == CTRL) begin
        o_cm_data <= lanes;
      end
    end
  end

endmodule

// File: tb/tb_cpri_rxdata_unpack.sv
// Directed bench for cpri_rxdata_unpack: a vector table plus frame sweeps and a
// mid-frame reset sequence.
module tb_cpri_rxdata_unpack;

  logic            i_clk = 1'b0;
  logic            i_reset;
  logic [63:0]     i_cpri_rx_data;
  logic [6:0]      i_cpri_rx_seq;
  logic [7:0][7:0] o_iq_data;
  logic [7:0][7:0] o_cm_data;

  int errors = 0;
  int checks = 0;

  cpri_rxdata_unpack #(.DW(8), .ANT(8), .numRE(12)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_cpri_rx_data (i_cpri_rx_data),
    .i_cpri_rx_seq  (i_cpri_rx_seq),
    .o_iq_data      (o_iq_data),
    .o_cm_data      (o_cm_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic        rst;
    logic [6:0]  seq;
    logic [63:0] data;
    logic [63:0] exp_iq;
    logic [63:0] exp_cm;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Present one word, clock it in, and leave time for the registers to settle.
  task automatic apply(input logic rst, input logic [6:0] seq, input logic [63:0] data);
    i_reset        = rst;
    i_cpri_rx_seq  = seq;
    i_cpri_rx_data = data;
    @(posedge i_clk);
    #1;
  endtask

  logic [63:0] exp_cm;
  logic [63:0] exp_iq;
  logic [63:0] d;
  logic [7:0]  lane_exp [8];

  initial begin
    i_reset        = 1'b1;
    i_cpri_rx_seq  = '0;
    i_cpri_rx_data = '0;

    //           rst   seq      data                    exp_iq                  exp_cm
    vecs[0]  = '{1'b1, 7'd0,   64'hDEAD_BEEF_0000_0001, 64'h0,                  64'h0};
    vecs[1]  = '{1'b0, 7'd0,   64'h5100_0000_0000_0000, 64'h0,                  64'h5100_0000_0000_0000};
    vecs[2]  = '{1'b0, 7'd4,   64'h1111_4321_1111_4321, 64'h1111_4321_1111_4321, 64'h5100_0000_0000_0000};
    vecs[3]  = '{1'b0, 7'd1,   64'h9100_0000_0000_00AB, 64'h0,                  64'h9100_0000_0000_00AB};
    vecs[4]  = '{1'b0, 7'd2,   64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 64'h9100_0000_0000_00AB};
    vecs[5]  = '{1'b0, 7'd95,  64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 64'h9100_0000_0000_00AB};
    vecs[6]  = '{1'b0, 7'd96,  64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  64'h9100_0000_0000_00AB};
    vecs[7]  = '{1'b0, 7'd100, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,                  64'h9100_0000_0000_00AB};
    vecs[8]  = '{1'b0, 7'd127, 64'h1234_5678_9ABC_DEF0, 64'h0,                  64'h9100_0000_0000_00AB};
    vecs[9]  = '{1'b0, 7'd0,   64'h0000_0000_0000_00AA, 64'h0,                  64'h0000_0000_0000_00AA};
    vecs[10] = '{1'b0, 7'd3,   64'h0000_0000_0000_0000, 64'h0,                  64'h0000_0000_0000_00AA};
    vecs[11] = '{1'b1, 7'd0,   64'h7777_7777_7777_7777, 64'h0,                  64'h0};
    vecs[12] = '{1'b0, 7'd5,   64'h0102_0304_0506_0708, 64'h0102_0304_0506_0708, 64'h0};

    lane_exp = '{8'h21, 8'h43, 8'h11, 8'h11, 8'h21, 8'h43, 8'h11, 8'h11};

    // Table-driven vectors, including reset entry and out-of-range seq values.
    for (int i = 0; i < 13; i++) begin
      apply(vecs[i].rst, vecs[i].seq, vecs[i].data);
      check($sformatf("vec%0d_iq", i), o_iq_data, vecs[i].exp_iq);
      check($sformatf("vec%0d_cm", i), o_cm_data, vecs[i].exp_cm);
      if (i == 1) begin
        check("ctrl_lane7", 64'(o_cm_data[7]), 64'h51);
      end
      if (i == 2) begin
        for (int a = 0; a < 8; a++) begin
          check($sformatf("iq_lane%0d", a), 64'(o_iq_data[a]), 64'(lane_exp[a]));
        end
      end
    end

    // Twenty full frames; frame 7 carries 0x91 in the top byte of its seq-1 word.
    exp_cm = 64'h0;
    for (int f = 0; f < 20; f++) begin
      for (int s = 0; s < 96; s++) begin
        d = {8'(f + 1), 1'b0, 7'(s), 16'h0, $urandom};
        if (f == 7 && s == 1) d = 64'h9100_0000_0000_0000 | 64'(f);
        apply(1'b0, 7'(s), d);
        exp_iq = (s >= 2) ? d : 64'h0;
        if (s <= 1) exp_cm = d;
        check($sformatf("sweep_f%0d_s%0d_iq", f, s), o_iq_data, exp_iq);
        check($sformatf("sweep_f%0d_s%0d_cm", f, s), o_cm_data, exp_cm);
        if (f == 7 && s >= 2) begin
          check($sformatf("sweep_f7_s%0d_cm7", s), 64'(o_cm_data[7]), 64'h91);
        end
      end
    end

    // Mid-frame resync: jump back to seq 0 after seq 40.
    apply(1'b0, 7'd40, 64'h4040_4040_4040_4040);
    check("jump_pre_iq", o_iq_data, 64'h4040_4040_4040_4040);
    apply(1'b0, 7'd0, 64'h00C0_FFEE_0000_0000);
    check("jump_iq", o_iq_data, 64'h0);
    check("jump_cm", o_cm_data, 64'h00C0_FFEE_0000_0000);

    // Reset asserted mid-frame at seq 50 for two cycles, then resync at seq 0.
    for (int s = 1; s < 50; s++) begin
      apply(1'b0, 7'(s), 64'hA5A5_0000_0000_0000 | 64'(s));
    end
    check("pre_rst_cm", o_cm_data, 64'hA5A5_0000_0000_0001);
    apply(1'b1, 7'd50, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst1_iq", o_iq_data, 64'h0);
    check("rst1_cm", o_cm_data, 64'h0);
    apply(1'b1, 7'd51, 64'hFFFF_FFFF_FFFF_FFFF);
    check("rst2_iq", o_iq_data, 64'h0);
    check("rst2_cm", o_cm_data, 64'h0);
    apply(1'b0, 7'd52, 64'h5252_5252_5252_5252);
    check("post_rst_iq", o_iq_data, 64'h5252_5252_5252_5252);
    check("post_rst_cm", o_cm_data, 64'h0);
    apply(1'b0, 7'd0, 64'h5100_0000_0000_0000);
    check("resync_cm", o_cm_data, 64'h5100_0000_0000_0000);
    check("resync_cm7", 64'(o_cm_data[7]), 64'h51);
    check("resync_iq", o_iq_data, 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
